// File: rtl/crc_stream_encoder.sv
// Streaming CRC encoder: forwards message beats, then appends the left-aligned remainder as CRC beats.
// Optional CRC_STREAM_ERR_INJECT_EN adds err_mask/err_inject to corrupt loaded output beats.
module crc_stream_encoder #(
  parameter int unsigned          DATA_W = 8,
  parameter int unsigned          CRC_W  = 6,
  parameter logic [CRC_W-1:0]     POLY   = 6'b111011,
  parameter logic [CRC_W-1:0]     INIT   = '0
) (
`ifdef CRC_STREAM_ERR_INJECT_EN
  input  logic [DATA_W-1:0] err_mask,
  input  logic              err_inject,
`endif
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              out_is_crc
);

  // state | meaning
  // MSG   | accepting message beats, remainder accumulating
  // CRC   | input closed, emitting CRC beats as the output slot frees

  localparam int unsigned CRC_BEATS = (CRC_W + DATA_W - 1) / DATA_W;
  localparam int unsigned PAD_W     = CRC_BEATS * DATA_W;
  localparam int unsigned CNT_W     = (CRC_BEATS > 1) ? $clog2(CRC_BEATS) : 1;

  typedef enum logic {MSG = 1'b0, CRC = 1'b1} state_t;

  state_t             state;
  logic [CRC_W-1:0]   rem;
  logic [CRC_W-1:0]   rem_next;
  logic [CNT_W-1:0]   cnt;
  logic               slot_free;
  logic               crc_final;
  logic [PAD_W-1:0]   rem_pad;
  logic [PAD_W-1:0]   rem_shift;
  logic [DATA_W-1:0]  crc_beat;
  logic [DATA_W-1:0]  inj;

  function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] r,
                                                input logic [DATA_W-1:0] d);
    logic [CRC_W-1:0] c;
    logic             fb;
    c = r;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      fb = c[CRC_W-1] ^ d[i];
      c  = {c[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
    end
    return c;
  endfunction

`ifdef CRC_STREAM_ERR_INJECT_EN
  assign inj = err_inject ? err_mask : '0;
`else
  assign inj = '0;
`endif

  assign slot_free = !out_valid || out_ready;
  assign in_ready  = (state == MSG) && slot_free;
  assign rem_next  = crc_step(rem, in_data);

  // Remainder is left-aligned across the CRC beats; beat k is the k-th DATA_W slice from the top.
  assign rem_pad   = PAD_W'(rem) << (PAD_W - CRC_W);
  assign rem_shift = rem_pad << (DATA_W * int'(cnt));
  assign crc_beat  = rem_shift[PAD_W-1 -: DATA_W];
  assign crc_final = (cnt == CNT_W'(CRC_BEATS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= MSG;
      rem        <= INIT;
      cnt        <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_last   <= 1'b0;
      out_is_crc <= 1'b0;
    end else if (slot_free) begin
      case (state)
        MSG: begin
          if (in_valid) begin
            out_valid  <= 1'b1;
            out_data   <= in_data ^ inj;
            out_last   <= 1'b0;
            out_is_crc <= 1'b0;
            rem        <= rem_next;
            if (in_last) begin
              state <= CRC;
              cnt   <= '0;
            end
          end else begin
            out_valid <= 1'b0;
          end
        end
        CRC: begin
          out_valid  <= 1'b1;
          out_data   <= crc_beat ^ inj;
          out_is_crc <= 1'b1;
          out_last   <= crc_final;
          if (crc_final) begin
            state <= MSG;
            rem   <= INIT;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= MSG;
      endcase
    end
  end

endmodule

// File: tb/tb_crc_stream_encoder.sv
// Bench for crc_stream_encoder: table-driven frames with a scoreboard queue, stall/reset/DATA_W=4 sequences.
// Exercises err_mask/err_inject when CRC_STREAM_ERR_INJECT_EN is defined.
module tb_crc_stream_encoder;

  typedef struct packed {
    logic [7:0] d;
    logic       last;
    logic       crc;
  } exp_t;

  typedef struct {
    int         n;
    logic [7:0] b [3];
    logic [7:0] crc;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, in_last;
  logic [7:0] in_data;
  logic       out_valid, out_ready, out_last, out_is_crc;
  logic [7:0] out_data;
  logic [7:0] err_mask;
  logic       err_inject;

  logic       in4_valid, in4_ready, in4_last;
  logic [3:0] in4_data;
  logic       out4_valid, out4_last, out4_is_crc;
  logic [3:0] out4_data;
  logic       out4_ready;
  logic [3:0] err4_mask;
  logic       err4_inject;

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t sbq[$];
  logic in_crc    = 1'b0;
  logic toggle_en = 1'b0;
  logic stall_prev = 1'b0;
  logic [9:0] stall_val;
  logic [7:0] fb [16];

  always #5 clk = ~clk;

  crc_stream_encoder dut (
`ifdef CRC_STREAM_ERR_INJECT_EN
    .err_mask(err_mask), .err_inject(err_inject),
`endif
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .out_is_crc(out_is_crc)
  );

  crc_stream_encoder #(.DATA_W(4)) dut4 (
`ifdef CRC_STREAM_ERR_INJECT_EN
    .err_mask(err4_mask), .err_inject(err4_inject),
`endif
    .clk(clk), .rst_n(rst_n),
    .in_valid(in4_valid), .in_ready(in4_ready), .in_data(in4_data), .in_last(in4_last),
    .out_valid(out4_valid), .out_ready(out4_ready), .out_data(out4_data),
    .out_last(out4_last), .out_is_crc(out4_is_crc)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
  endtask

  // Reference remainder by long division of msg*x^6 by the full generator x^6+POLY.
  function automatic logic [7:0] ref_crc(input int n);
    logic [135:0] v;
    v = '0;
    for (int j = 0; j < n; j++) v = (v << 8) | 136'(fb[j]);
    v = v << 6;
    for (int i = 135; i >= 6; i--)
      if (v[i]) v[i -: 7] = v[i -: 7] ^ 7'b1111011;
    return {v[5:0], 2'b00};
  endfunction

  // Out_ready pattern 1,0,0,1 when enabled, else held high.
  initial begin
    int idx = 0;
    logic [3:0] pat = 4'b1001;
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (toggle_en) begin out_ready = pat[3 - (idx % 4)]; idx++; end
      else out_ready = 1'b1;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) stall_prev = 1'b0;
    else begin
      if (stall_prev && out_valid)
        chk("stall_hold", {out_data, out_last, out_is_crc}, stall_val);
      stall_prev = out_valid && !out_ready;
      stall_val  = {out_data, out_last, out_is_crc};
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) chk("unexpected_beat", {out_data, out_last, out_is_crc}, 32'hFFFF);
        else begin
          e = sbq.pop_front();
          chk("beat_data", out_data, e.d);
          chk("beat_last", out_last, e.last);
          chk("beat_is_crc", out_is_crc, e.crc);
        end
      end
      if (out_valid && out_is_crc && out_last) in_crc = 1'b0;
      else if (in_crc) chk("in_ready_during_crc", in_ready, 0);
    end
  end

  // Entered and left at posedge+1; pushes the message beat and, on last, the CRC beat.
  task automatic drive_beat(input logic [7:0] d, input logic last, input logic [7:0] crc);
    int t = 0;
    in_valid = 1'b1; in_data = d; in_last = last;
    #1;
    while (!in_ready && t < 200) begin @(posedge clk); #2; t++; end
    if (t >= 200) chk("accept_timeout", t, 0);
    sbq.push_back('{d: d, last: 1'b0, crc: 1'b0});
    @(posedge clk); #1;
    if (last) begin
      sbq.push_back('{d: crc, last: 1'b1, crc: 1'b1});
      in_crc = 1'b1;
    end
    in_valid = 1'b0; in_last = 1'b0; in_data = 8'h5A;
  endtask

  task automatic send_frame(input int n, input logic [7:0] crc);
    for (int j = 0; j < n; j++) drive_beat(fb[j], j == n - 1, crc);
  endtask

  task automatic drain();
    int t = 0;
    while (sbq.size() != 0 && t < 500) begin @(posedge clk); t++; end
    chk("drain_empty", sbq.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    vec_t vecs [6];
    vecs[0] = '{n: 1, b: '{8'h01, 8'h00, 8'h00}, crc: 8'hEC};
    vecs[1] = '{n: 1, b: '{8'h02, 8'h00, 8'h00}, crc: 8'h34};
    vecs[2] = '{n: 1, b: '{8'h03, 8'h00, 8'h00}, crc: 8'hD8};
    vecs[3] = '{n: 1, b: '{8'h00, 8'h00, 8'h00}, crc: 8'h00};
    vecs[4] = '{n: 2, b: '{8'h00, 8'h01, 8'h00}, crc: 8'hEC};
    vecs[5] = '{n: 1, b: '{8'h02, 8'h00, 8'h00}, crc: 8'h34};

    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0;
    err_mask = 8'h00; err_inject = 1'b0; err4_mask = 4'h0; err4_inject = 1'b0;
    in4_valid = 1'b0; in4_data = 4'h0; in4_last = 1'b0; out4_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_is_crc", out_is_crc, 0);
    chk("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[v]) begin
      for (int j = 0; j < 3; j++) fb[j] = vecs[v].b[j];
      send_frame(vecs[v].n, vecs[v].crc);
    end
    drain();

    // First CRC beat must directly follow the last message beat.
    drive_beat(8'h02, 1'b1, 8'h34);
    @(posedge clk); #1;
    chk("nogap_valid", out_valid, 1);
    chk("nogap_is_crc", out_is_crc, 1);
    chk("nogap_data", out_data, 8'h34);
    drain();

    toggle_en = 1'b1;
    fb[0] = 8'h01;
    send_frame(1, 8'hEC);
    for (int f = 0; f < 6; f++) begin
      int n = $urandom_range(1, 4);
      for (int j = 0; j < n; j++) fb[j] = 8'($urandom);
      send_frame(n, ref_crc(n));
    end
    drain();
    toggle_en = 1'b0;
    @(posedge clk); #1;

    // Reset after first beat of a 3-beat frame.
    drive_beat(8'hAA, 1'b0, 8'h00);
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_data", out_data, 0);
    chk("midrst_out_is_crc", out_is_crc, 0);
    sbq.delete();
    in_crc = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    fb[0] = 8'h01;
    send_frame(1, 8'hEC);
    drain();

`ifdef CRC_STREAM_ERR_INJECT_EN
    in_valid = 1'b1; in_data = 8'h01; in_last = 1'b1;
    err_mask = 8'h80; err_inject = 1'b1;
    #1;
    chk("inj_in_ready", in_ready, 1);
    sbq.push_back('{d: 8'h81, last: 1'b0, crc: 1'b0});
    @(posedge clk); #1;
    sbq.push_back('{d: 8'hEC, last: 1'b1, crc: 1'b1});
    in_crc = 1'b1;
    in_valid = 1'b0; in_last = 1'b0; err_inject = 1'b0;
    drain();
`endif

    // DATA_W=4 instance: 0x0, 0x1(last) -> CRC beats 0xE, 0xC.
    in4_valid = 1'b1; in4_data = 4'h0; in4_last = 1'b0;
    @(posedge clk); #1;
    chk("w4_b0_data", out4_data, 4'h0);
    chk("w4_b0_is_crc", out4_is_crc, 0);
    in4_data = 4'h1; in4_last = 1'b1;
    @(posedge clk); #1;
    chk("w4_b1_data", out4_data, 4'h1);
    in4_valid = 1'b0; in4_last = 1'b0;
    chk("w4_in_ready_crc", in4_ready, 0);
    @(posedge clk); #1;
    chk("w4_crc0", {out4_valid, out4_data, out4_last, out4_is_crc}, {1'b1, 4'hE, 1'b0, 1'b1});
    @(posedge clk); #1;
    chk("w4_crc1", {out4_valid, out4_data, out4_last, out4_is_crc}, {1'b1, 4'hC, 1'b1, 1'b1});
    @(posedge clk); #1;
    chk("w4_idle_valid", out4_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/crc_stream_encoder.md
Name: crc_stream_encoder

Overview:
Streaming, clocked successor to the combinational CRC appender. It accepts a message as a sequence of DATA_W-bit beats over a valid/ready handshake and forwards each beat unchanged. After the beat marked last, it appends the CRC remainder as one or more extra beats. It sits between a frame source and the channel/error-injection model in the error-analysis datapath.

Parameters:
DATA_W, 8, bits per beat; MSB of a beat is transmitted first.
CRC_W, 6, remainder width, equal to the generator degree.
POLY, 6'b111011, generator with the implicit leading x^CRC_W term dropped; the default is g(x)=x^6+x^5+x^4+x^3+x+1.
INIT, 0, remainder preset at the start of every frame.
CRC_BEATS, ceil(CRC_W/DATA_W), number of appended CRC beats; derived, not overridable.

Ports:
clk  in  1  system clock.
rst_n  in  1  asynchronous active-low reset.
in_valid  in  1  input beat valid.
in_ready  out  1  encoder can accept a beat.
in_data  in  DATA_W  message beat.
in_last  in  1  final message beat of the frame.
out_valid  out  1  output beat valid.
out_ready  in  1  downstream accepts the beat.
out_data  out  DATA_W  message beat or CRC beat.
out_last  out  1  final CRC beat of the frame.
out_is_crc  out  1  current output beat carries CRC bits.

Behaviour:
- Reset: async on rst_n low. Forces state=MSG, remainder=INIT, beat counter=0, out_valid=0, out_data=0, out_last=0, out_is_crc=0. Sync deassert is external.
- Output stage: single register stage; out_* change only when out_valid=0 or out_ready=1.
- Hold rule: while out_valid=1 and out_ready=0, out_data, out_last and out_is_crc hold stable.
- in_ready = (state==MSG) && (!out_valid || out_ready); combinational; never depends on in_valid.
- Accept: in_valid && in_ready. On the next edge:
  - out_data <= in_data, out_valid <= 1, out_is_crc <= 0, out_last <= 0.
  - Remainder advances DATA_W bits, MSB first. Per bit b: fb = rem[CRC_W-1]^b; rem = {rem[CRC_W-2:0],1'b0} ^ (fb ? POLY : 0).
  - Result equals the remainder of msg·x^CRC_W mod g: no reflection, no final XOR.
- Message latency: 1 cycle from accept to out_valid.
- State MSG: an accepted beat with in_last=1 moves to CRC with the updated remainder latched and the beat counter cleared.
- State CRC: in_ready=0.
  - Each time the output slot frees, emit CRC beat k = bits [CRC_W-1-k·DATA_W -: DATA_W] of the remainder, left-aligned. Unused LSBs of the final beat are 0.
  - out_is_crc=1 on every CRC beat; out_last=1 on beat CRC_BEATS-1.
  - After the last CRC beat is loaded into the output stage: state returns to MSG, remainder returns to INIT.
  - The first CRC beat follows the last message beat with no gap when out_ready=1.
- A frame is at least one beat. in_last on the first beat is legal and gives a single-beat frame.
- Back-to-back frames: a new frame's first beat is accepted no earlier than the cycle after the last CRC beat is loaded.
- Throughput: with out_ready held high, one beat per cycle, plus CRC_BEATS cycles per frame.
- Reset mid-frame: the partial frame is discarded, with no CRC emitted and out_valid=0 immediately.
- in_data is ignored when in_valid=0. X on in_data while in_valid=0 must not propagate into the remainder.

Optional Feature:
Macro CRC_STREAM_ERR_INJECT_EN.
- Defined: adds ports err_mask (in, DATA_W) and err_inject (in, 1). When err_inject=1 during a cycle in which a beat is loaded into the output stage, that beat's out_data is XORed with err_mask. This applies to message or CRC beats. The remainder is always computed on the clean in_data, so the injected errors remain detectable downstream.
- Undefined: the ports do not exist and out_data is never modified.

Test Plan:
1. DATA_W=8, POLY default: send single beat 0x01 with last, out_ready=1 -> outputs 0x01 (is_crc=0), then 0xEC (is_crc=1, last=1). Remainder 6'b111011.
2. Single beat 0x02 -> 0x02 then CRC beat 0x34 (remainder 6'b001101). Single beat 0x03 -> CRC beat 0xD8; single beat 0x00 -> CRC beat 0x00.
3. Two beats 0x00, 0x01(last) -> CRC beat 0xEC. Then an immediate second frame 0x02(last) -> CRC 0x34; remainder reset between frames confirmed.
4. DATA_W=4: beats 0x0, 0x1(last) -> CRC beats 0xE then 0xC; out_last set only on 0xC.
5. Frame 0x01 with out_ready toggling 1,0,0,1 every cycle -> no beat lost or duplicated, out_data stable while stalled, in_ready=0 throughout CRC emission.
6. Assert rst_n low after the first beat of a 3-beat frame -> out_valid=0 during reset. The next frame 0x01 yields CRC 0xEC.
   With CRC_STREAM_ERR_INJECT_EN, inject mask 0x80 on the 0x01 beat -> out 0x81 then 0xEC.
